// File: rtl/fix_field_writer_if.sv
// Byte-stream input, RAM port-0 write side and per-message status
// of the FIX field writer.
interface fix_field_writer_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic                  in_valid;
    logic                  in_ready;
    logic [7:0]            in_data;
    logic                  in_last;
    logic                  ram_cs;
    logic                  ram_we;
    logic                  ram_oe;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_data;
    logic                  msg_done;
    logic                  msg_err;
    logic [ADDR_WIDTH-1:0] field_count;

    modport master (
        input  in_valid, in_data, in_last,
        output in_ready,
        output ram_cs, ram_we, ram_oe, ram_addr, ram_data,
        output msg_done, msg_err, field_count
    );

    modport slave (
        output in_valid, in_data, in_last,
        input  in_ready,
        input  ram_cs, ram_we, ram_oe, ram_addr, ram_data,
        input  msg_done, msg_err, field_count
    );
endinterface

// File: rtl/fix_field_writer.sv
// Parses a raw FIX tag=value<SOH> stream and writes one header word
// plus packed little-endian value words per field into port 0 of the RAM.
module fix_field_writer #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 16
) (
    input  logic               clk,
    input  logic               rst,
    fix_field_writer_if.master bus
);
    localparam int BPW = DATA_WIDTH / 8;
    localparam int BW  = $clog2(BPW);
    localparam int AW2 = ADDR_WIDTH + 2;
    localparam int TW4 = TAG_WIDTH + 4;
    localparam logic [AW2-1:0] LAST_ADDR = AW2'((1 << ADDR_WIDTH) - 1);
    localparam logic [TW4-1:0] TAG_MAX = {4'b0, {TAG_WIDTH{1'b1}}};

    typedef enum logic [2:0] {
        S_TAG, S_VALUE, S_FLUSH, S_HDR, S_ERR
    } state_t;

    state_t                state_q;
    logic [TAG_WIDTH-1:0]  tag_q;
    logic                  have_dig_q;
    logic [15:0]           len_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic [BW-1:0]         bcnt_q;
    logic [ADDR_WIDTH:0]   widx_q;
    logic [ADDR_WIDTH:0]   base_q;
    logic [ADDR_WIDTH-1:0] cnt_q;
    logic                  last_q;
    logic                  ram_cs_q;
    logic [ADDR_WIDTH-1:0] ram_addr_q;
    logic [DATA_WIDTH-1:0] ram_data_q;
    logic                  msg_done_q;
    logic                  msg_err_q;
    logic [ADDR_WIDTH-1:0] field_count_q;

    logic                  xfer, soh, is_dig, is_eq;
    logic                  partial, full, tag_ovf;
    logic                  waddr_ovf, hdr_ovf, term_last;
    logic                  hdr_go, err_now, err_end;
    logic [TW4-1:0]        tag_nx;
    logic [AW2-1:0]        waddr;
    logic [DATA_WIDTH-1:0] word_nx, hdr_word;

    assign bus.in_ready = !rst &&
        (state_q inside {S_TAG, S_VALUE, S_ERR});
    assign xfer   = bus.in_valid && bus.in_ready;
    assign soh    = bus.in_data == 8'h01;
    assign is_eq  = bus.in_data == 8'h3D;
    assign is_dig = bus.in_data >= 8'h30 && bus.in_data <= 8'h39;

    assign tag_nx = TW4'(tag_q) * TW4'(10) + TW4'(bus.in_data[3:0]);
    assign tag_ovf = tag_nx > TAG_MAX;

    assign partial = bcnt_q != '0;
    assign full    = bcnt_q == BW'(BPW - 1);

    // next value-word address; equals the next field base once all words are out
    assign waddr     = AW2'(base_q) + AW2'(widx_q) + AW2'(1);
    assign waddr_ovf = waddr > LAST_ADDR;
    assign hdr_ovf   = AW2'(base_q) > LAST_ADDR;
    assign term_last = (state_q == S_FLUSH) ? last_q : bus.in_last;

    always_comb begin
        word_nx = word_q;
        word_nx[{bcnt_q, 3'b000} +: 8] = bus.in_data;
        hdr_word = '0;
        hdr_word[15:0]  = len_q;
        hdr_word[31:16] = 16'(tag_q);
    end

    always_comb begin
        err_now = 1'b0;
        unique case (state_q)
            S_TAG: err_now = xfer && (bus.in_last ||
                !((is_dig && !tag_ovf) || (is_eq && have_dig_q)));
            S_VALUE: err_now = xfer && (soh ?
                (partial ? waddr_ovf : hdr_ovf) :
                (bus.in_last || (full && waddr_ovf)));
            S_FLUSH: err_now = hdr_ovf;
            default: err_now = 1'b0;
        endcase
    end

    assign err_end = (err_now && term_last) ||
        (state_q == S_ERR && xfer && bus.in_last);
    assign hdr_go = !err_now && (state_q == S_FLUSH ||
        (state_q == S_VALUE && xfer && soh && !partial));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_TAG;
            tag_q         <= '0;
            have_dig_q    <= 1'b0;
            len_q         <= '0;
            word_q        <= '0;
            bcnt_q        <= '0;
            widx_q        <= '0;
            base_q        <= '0;
            cnt_q         <= '0;
            last_q        <= 1'b0;
            ram_cs_q      <= 1'b0;
            ram_addr_q    <= '0;
            ram_data_q    <= '0;
            msg_done_q    <= 1'b0;
            msg_err_q     <= 1'b0;
            field_count_q <= '0;
        end else begin
            ram_cs_q   <= 1'b0;
            msg_done_q <= 1'b0;
            msg_err_q  <= 1'b0;
            if (err_now || err_end) begin
                tag_q      <= '0;
                have_dig_q <= 1'b0;
                len_q      <= '0;
                word_q     <= '0;
                bcnt_q     <= '0;
                widx_q     <= '0;
                base_q     <= '0;
                cnt_q      <= '0;
                last_q     <= 1'b0;
                state_q    <= err_end ? S_TAG : S_ERR;
                if (err_end) begin
                    msg_err_q     <= 1'b1;
                    field_count_q <= '0;
                end
            end else if (hdr_go) begin
                ram_cs_q   <= 1'b1;
                ram_addr_q <= base_q[ADDR_WIDTH-1:0];
                ram_data_q <= hdr_word;
                tag_q      <= '0;
                have_dig_q <= 1'b0;
                len_q      <= '0;
                widx_q     <= '0;
                last_q     <= 1'b0;
                state_q    <= S_HDR;
                if (term_last) begin
                    msg_done_q    <= 1'b1;
                    field_count_q <= cnt_q + 1'b1;
                    base_q        <= '0;
                    cnt_q         <= '0;
                end else begin
                    base_q <= waddr[ADDR_WIDTH:0];
                    cnt_q  <= cnt_q + 1'b1;
                end
            end else begin
                unique case (state_q)
                    S_TAG: if (xfer) begin
                        if (is_dig) begin
                            tag_q      <= tag_nx[TAG_WIDTH-1:0];
                            have_dig_q <= 1'b1;
                        end else begin
                            state_q <= S_VALUE;
                        end
                    end
                    S_VALUE: if (xfer) begin
                        if (soh) begin
                            // only reached with a partial word pending
                            last_q     <= bus.in_last;
                            ram_cs_q   <= 1'b1;
                            ram_addr_q <= waddr[ADDR_WIDTH-1:0];
                            ram_data_q <= word_q;
                            word_q     <= '0;
                            bcnt_q     <= '0;
                            widx_q     <= widx_q + 1'b1;
                            state_q    <= S_FLUSH;
                        end else begin
                            len_q <= len_q + 16'd1;
                            if (full) begin
                                ram_cs_q   <= 1'b1;
                                ram_addr_q <= waddr[ADDR_WIDTH-1:0];
                                ram_data_q <= word_nx;
                                word_q     <= '0;
                                bcnt_q     <= '0;
                                widx_q     <= widx_q + 1'b1;
                            end else begin
                                word_q <= word_nx;
                                bcnt_q <= bcnt_q + 1'b1;
                            end
                        end
                    end
                    S_HDR: state_q <= S_TAG;
                    default: ;
                endcase
            end
        end
    end

    assign bus.ram_cs      = ram_cs_q;
    assign bus.ram_we      = ram_cs_q;
    assign bus.ram_oe      = 1'b0;
    assign bus.ram_addr    = ram_addr_q;
    assign bus.ram_data    = ram_data_q;
    assign bus.msg_done    = msg_done_q;
    assign bus.msg_err     = msg_err_q;
    assign bus.field_count = field_count_q;
endmodule
